// File: rtl/plic_arbiter.sv
// Interrupt gateway and priority scheduler for PLIC hart context 0.
// Level sources become pending bits; the highest-priority eligible source is offered to the core.
module plic_arbiter #(
    parameter int unsigned NSRC = 16,
    parameter int unsigned PW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NSRC-1:0]    irq_src,
    input  logic [NSRC*PW-1:0] prio,
    input  logic [NSRC-1:0]    ie,
    input  logic [PW-1:0]      ith,
    output logic [NSRC-1:0]    ip,
    output logic [4:0]         cpc_id,
    output logic               trap_valid,
    output logic [4:0]         trap_id,
    input  logic               trap_ready,
    input  logic               trap_cplet,
    input  logic [4:0]         trap_cplet_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERV
    } state_t;

    localparam logic [NSRC-1:0] SRC_MASK = {{(NSRC-1){1'b1}}, 1'b0};
    localparam logic [NSRC-1:0] ONE_HOT0 = {{(NSRC-1){1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [NSRC-1:0] gate;
    logic [NSRC-1:0] ip_nxt, gate_nxt;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] claim_vec, cplet_vec;
    logic [4:0]      trap_id_nxt, cpc_id_nxt;
    logic [4:0]      best;
    logic [PW-1:0]   best_prio;
    logic            best_v;
    logic            claim;
    logic            cplet_ok;

    // IDs 0 and >= NSRC never complete anything.
    assign cplet_ok  = trap_cplet && (trap_cplet_id != 5'd0) && (32'(trap_cplet_id) < NSRC);
    assign cplet_vec = cplet_ok ? (ONE_HOT0 << trap_cplet_id) : '0;
    assign claim_vec = claim ? (ONE_HOT0 << trap_id) : '0;

    // Setting uses the registered gate, so a same-cycle completion clear wins
    // and the source re-pends one cycle later; a claim blocks its own re-pend.
    assign ip_nxt   = (ip | (irq_src & ~gate)) & ~claim_vec & SRC_MASK;
    assign gate_nxt = ((gate & ~cplet_vec) | claim_vec) & SRC_MASK;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            elig[i] = ip[i] & ie[i] & (prio[i*PW +: PW] > ith);
        end
    end

    // Strict greater-than keeps the lowest ID on priority ties.
    always_comb begin
        best_v    = 1'b0;
        best      = '0;
        best_prio = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (elig[i] && (!best_v || (prio[i*PW +: PW] > best_prio))) begin
                best_v    = 1'b1;
                best      = 5'(i);
                best_prio = prio[i*PW +: PW];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        trap_id_nxt = trap_id;
        cpc_id_nxt  = cpc_id;
        claim       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (best_v) begin
                    trap_id_nxt = best;
                    state_nxt   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (trap_ready) begin
                    claim      = 1'b1;
                    cpc_id_nxt = trap_id;
                    state_nxt  = ST_SERV;
                end else if (!best_v) begin
                    state_nxt = ST_IDLE;
                end else begin
                    trap_id_nxt = best;
                end
            end
            ST_SERV: begin
                if (cplet_ok && (trap_cplet_id == cpc_id)) begin
                    cpc_id_nxt = '0;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ip      <= '0;
            gate    <= '0;
            trap_id <= '0;
            cpc_id  <= '0;
        end else begin
            state   <= state_nxt;
            ip      <= ip_nxt;
            gate    <= gate_nxt;
            trap_id <= trap_id_nxt;
            cpc_id  <= cpc_id_nxt;
        end
    end

    assign trap_valid = (state == ST_REQ);

endmodule

// File: tb/tb_plic_arbiter.sv
// Scoreboard bench for plic_arbiter: a priority-scan reference model predicts each cycle's outputs,
// a negedge monitor pops and compares them.
module tb_plic_arbiter;

    localparam int NSRC = 16;
    localparam int PW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NSRC-1:0]    irq_src;
    logic [NSRC*PW-1:0] prio;
    logic [NSRC-1:0]    ie;
    logic [PW-1:0]      ith;
    logic [NSRC-1:0]    ip;
    logic [4:0]         cpc_id;
    logic               trap_valid;
    logic [4:0]         trap_id;
    logic               trap_ready;
    logic               trap_cplet;
    logic [4:0]         trap_cplet_id;

    always #5 clk = ~clk;

    plic_arbiter #(.NSRC(NSRC), .PW(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_src      (irq_src),
        .prio         (prio),
        .ie           (ie),
        .ith          (ith),
        .ip           (ip),
        .cpc_id       (cpc_id),
        .trap_valid   (trap_valid),
        .trap_id      (trap_id),
        .trap_ready   (trap_ready),
        .trap_cplet   (trap_cplet),
        .trap_cplet_id(trap_cplet_id)
    );

    typedef struct packed {
        logic [NSRC-1:0] ip;
        logic            valid;
        logic [4:0]      id;
        logic            chk_id;
        logic [4:0]      cpc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: pending/gated flags, the ID being offered and the ID in service.
    logic [NSRC-1:0] mp, mg;
    bit              m_valid;
    int              m_id, m_serv;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int model_best();
        for (int p = (1 << PW) - 1; p >= 1; p--) begin
            if (p > int'(ith)) begin
                for (int i = 1; i < NSRC; i++) begin
                    if (mp[i] && ie[i] && int'(prio[i*PW +: PW]) == p) return i;
                end
            end
        end
        return 0;
    endfunction

    task automatic model_step();
        int best, claimed;
        bit cv, chk;
        logic [NSRC-1:0] np, ng;
        chk = 1'b0;
        if (rst) begin
            mp = '0; mg = '0; m_valid = 1'b0; m_id = 0; m_serv = 0; chk = 1'b1;
        end else begin
            best    = model_best();
            claimed = 0;
            cv      = trap_cplet && trap_cplet_id != 0 && int'(trap_cplet_id) < NSRC;
            if (m_valid) begin
                if (trap_ready) begin
                    claimed = m_id; m_serv = m_id; m_valid = 1'b0;
                end else if (best == 0) m_valid = 1'b0;
                else m_id = best;
            end else if (m_serv != 0) begin
                if (cv && int'(trap_cplet_id) == m_serv) m_serv = 0;
            end else if (best != 0) begin
                m_valid = 1'b1; m_id = best;
            end
            np = '0; ng = '0;
            for (int i = 1; i < NSRC; i++) begin
                ng[i] = (mg[i] && !(cv && int'(trap_cplet_id) == i)) || (claimed == i);
                np[i] = (mp[i] || (irq_src[i] && !mg[i])) && (claimed != i);
            end
            mp = np; mg = ng;
        end
        sb.push_back('{ip: mp, valid: m_valid, id: 5'(m_id), chk_id: chk || m_valid, cpc: 5'(m_serv)});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_prio(input int i, input int p);
        prio[i*PW +: PW] = PW'(p);
    endtask

    task automatic do_reset();
        irq_src = '0; prio = '0; ie = '0; ith = '0;
        trap_ready = 1'b0; trap_cplet = 1'b0; trap_cplet_id = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic serve_one(input bit drop);
        int n, id;
        n = 0;
        while (!m_valid && n < 20) begin step(); n++; end
        if (!m_valid) begin
            checks++;
            $display("FAIL offer_timeout: got no offer expected offer within 20 cycles");
        end
        trap_ready = 1'b1;
        step();
        trap_ready = 1'b0;
        id = m_serv;
        if (drop && id != 0) irq_src[id] = 1'b0;
        step();
        trap_cplet = 1'b1; trap_cplet_id = 5'(id);
        step();
        trap_cplet = 1'b0; trap_cplet_id = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ip", int'(ip), int'(e.ip));
                check("trap_valid", int'(trap_valid), int'(e.valid));
                check("cpc_id", int'(cpc_id), int'(e.cpc));
                if (e.chk_id) check("trap_id", int'(trap_id), int'(e.id));
            end
        end
    end

    initial begin : stimulus
        m_valid = 1'b0; m_id = 0; m_serv = 0; mp = '0; mg = '0;
        rst = 1'b1; irq_src = '0; prio = '0; ie = '0; ith = '0;
        trap_ready = 1'b0; trap_cplet = 1'b0; trap_cplet_id = '0;
        #2;

        // Single source: pend, offer, claim, complete with level still high, re-offer.
        do_reset();
        irq_src[3] = 1'b1; ie = 16'h0008; set_prio(3, 2);
        run(2);
        trap_ready = 1'b1; step(); trap_ready = 1'b0;
        run(2);
        trap_cplet = 1'b1; trap_cplet_id = 5'd3; step(); trap_cplet = 1'b0;
        run(4);

        // Priority order 12, then 5, then 9.
        do_reset();
        ie = '1; set_prio(5, 1); set_prio(9, 1); set_prio(12, 3);
        irq_src[5] = 1'b1; irq_src[9] = 1'b1; irq_src[12] = 1'b1;
        serve_one(1'b1);
        serve_one(1'b1);
        serve_one(1'b1);
        run(3);

        // Threshold gating.
        do_reset();
        ie = '1; set_prio(4, 1); ith = 2'd1; irq_src[4] = 1'b1;
        run(5);
        ith = 2'd0;
        run(3);
        serve_one(1'b1);

        // Retarget before claim, then withdraw.
        do_reset();
        ie = '1; set_prio(2, 1); set_prio(7, 3); irq_src[2] = 1'b1;
        run(2);
        irq_src[7] = 1'b1;
        run(3);
        ie[7] = 1'b0; ie[2] = 1'b0;
        run(3);

        // Foreign completion while in service.
        do_reset();
        ie = '1; set_prio(6, 3); set_prio(8, 1); irq_src[6] = 1'b1;
        run(2);
        trap_ready = 1'b1; step(); trap_ready = 1'b0;
        trap_cplet = 1'b1; trap_cplet_id = 5'd8; step();
        trap_cplet_id = 5'd0; step();
        trap_cplet_id = 5'd6; step(); trap_cplet = 1'b0;
        run(3);

        // Reset while in service forgets the claim.
        do_reset();
        ie = '1; set_prio(10, 2); irq_src[10] = 1'b1;
        run(2);
        trap_ready = 1'b1; step(); trap_ready = 1'b0;
        run(2);
        rst = 1'b1; step(); rst = 1'b0;
        run(4);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(199) == 0);
            if ($urandom_range(3) == 0)  irq_src = 16'($urandom);
            if ($urandom_range(15) == 0) prio = 32'($urandom);
            if ($urandom_range(15) == 0) ie = 16'($urandom);
            if ($urandom_range(15) == 0) ith = 2'($urandom);
            trap_ready    = ($urandom_range(2) == 0);
            trap_cplet    = ($urandom_range(3) == 0);
            trap_cplet_id = ($urandom_range(1) == 0) ? 5'(m_serv) : 5'($urandom);
            step();
        end
        rst = 1'b0; trap_ready = 1'b0; trap_cplet = 1'b0;

        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/plic_arbiter.md
# plic_arbiter

Interrupt gateway and priority scheduler sitting between the PLIC register file and the core's external-trap port (hart context 0). It turns 16 level-sensitive interrupt sources into per-source pending bits and picks the highest-priority enabled pending source above the context threshold. It runs the request/claim/complete handshake with the core, allowing one outstanding interrupt at a time. It drives the pending bits and claim ID that the register file exposes read-only.

## Interface
- NSRC, 16: number of source IDs including reserved ID 0. ID 0 never pends.
- PW, 2: priority/threshold width.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  NSRC  level-sensitive interrupt sources; bit 0 ignored.
- prio  in  NSRC*PW  packed per-source priority; bits [i*PW+:PW] belong to source i. 0 = never eligible.
- ie  in  NSRC  per-source enable.
- ith  in  PW  context priority threshold.
- ip  out  NSRC  registered pending bits.
- cpc_id  out  5  ID currently in service, 0 when none.
- trap_valid  out  1  external interrupt request to core.
- trap_id  out  5  ID offered with trap_valid.
- trap_ready  in  1  core accepts the offered ID (claim).
- trap_cplet  in  1  core completion strobe.
- trap_cplet_id  in  5  ID being completed.

## Operation
- Gateway per source i≥1:
  - ip[i] sets when irq_src[i]=1, ip[i]=0 and gate[i]=0.
  - At claim, ip[i] clears and gate[i] sets.
  - gate[i] clears on trap_cplet with trap_cplet_id==i.
  - While gate[i]=1, the source cannot re-pend.
- Eligibility: elig[i] = ip[i] & ie[i] & (prio[i] > ith). The comparison is unsigned on PW bits.
- Selection is combinational over elig. Highest prio wins; ties go to the lowest ID. best_v=0 when no source is eligible.
- FSM states:
  - IDLE: trap_valid=0. If best_v, load trap_id<=best and go to REQ.
  - REQ: trap_valid=1.
    - trap_ready=1: claim trap_id (ip clear, gate set), cpc_id<=trap_id, go to SERV.
    - Else if best_v=0: go to IDLE with trap_valid=0 (withdraw).
    - Else: trap_id<=best (a higher-priority arrival or config change re-targets before claim).
  - SERV: trap_valid=0.
    - trap_cplet with trap_cplet_id==cpc_id: cpc_id<=0, go to IDLE.
    - A completion with another ID only clears that ID's gate. The FSM stays in SERV.
- trap_cplet_id of 0 or ≥NSRC is ignored.
- Same-cycle events:
  - A gateway set and a completion clear for the same i in one cycle: the clear wins. The source may re-pend the following cycle.
  - A claim and irq_src still high for the same source: the source stays non-pending because gate is set.
- ip[0], gate[0] are tied to 0.

## Timing
- Reset values: ip=0, gate=0, state=IDLE, trap_valid=0, trap_id=0, cpc_id=0.
- Reset mid-operation returns to IDLE in one cycle. The outstanding claim is forgotten: no gate is held and sources re-pend normally.
- Latency from irq_src high at edge N sampled:
  - ip set after edge N.
  - trap_valid=1 after edge N+1 (2 cycles), provided the FSM is in IDLE.
- Claim handshake:
  - trap_valid&trap_ready sampled at edge M.
  - After edge M: trap_valid=0, ip bit clear, cpc_id valid.
- Completion at edge K: cpc_id=0 and FSM in IDLE after K. The next trap_valid comes earliest after edge K+1.
- trap_ready while trap_valid=0 is ignored.
- trap_id is stable while trap_valid=1 and trap_ready=1.

## Test plan
- Reset, then irq_src[3]=1, ie=16'h0008, prio[3]=2, ith=0 -> ip=0x0008 one cycle later, trap_valid=1 and trap_id=3 one cycle after that. Assert trap_ready -> ip=0, cpc_id=3, trap_valid=0. Complete ID 3 with irq_src[3] still 1 -> ip[3] re-pends and trap_id=3 is offered again.
- Sources 5 and 9 pending at prio 1, source 12 at prio 3, all enabled -> trap_id=12. After it is claimed and completed -> 5 is offered, and 9 only after 5 completes.
- prio[4]=1 with ith=1 -> no trap_valid. Lower ith to 0 -> trap_valid=1, trap_id=4.
- In REQ offering ID 2 (prio 1), source 7 (prio 3) pends before ready -> trap_id changes to 7. Clearing ie[7] and ie[2] before ready -> trap_valid drops.
- In SERV for ID 6, complete with ID 8 -> FSM stays in SERV, cpc_id=6. Complete ID 6 -> IDLE.
- Assert rst while in SERV with ID 10 -> all outputs 0 next cycle. irq_src[10] still high -> re-pends and is offered again after 2 cycles.
